// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging two writeback requesters into one registered register-file write port.
// Latency 1 (handshake at t -> rf write at t+1); the losing requester simply sees ready low and holds its request.
module regfile_wb_arbiter #(
    parameter int N = 5,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    input  logic [N-1:0] a_addr,
    input  logic [M-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [N-1:0] b_addr,
    input  logic [M-1:0] b_data,
    output logic         b_ready,
    output logic         rf_we,
    output logic [N-1:0] rf_wa,
    output logic [M-1:0] rf_wd,
    input  logic [N-1:0] rd_a1,
    input  logic [N-1:0] rd_a2,
    output logic         fwd1,
    output logic         fwd2,
    output logic [M-1:0] fwd_data,
    output logic         haz1,
    output logic         haz2
);

    logic         r_last_b;
    logic         r_we;
    logic [N-1:0] r_wa;
    logic [M-1:0] r_wd;
    logic         w_grant_a;
    logic         w_grant_b;

    // On contention the requester not granted most recently wins.
    assign w_grant_a = !reset && a_valid && (!b_valid || r_last_b);
    assign w_grant_b = !reset && b_valid && (!a_valid || !r_last_b);

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_last_b <= 1'b1;
        end else if (w_grant_a) begin
            r_we     <= (a_addr != '0);
            r_wa     <= a_addr;
            r_wd     <= a_data;
            r_last_b <= 1'b0;
        end else if (w_grant_b) begin
            r_we     <= (b_addr != '0);
            r_wa     <= b_addr;
            r_wd     <= b_data;
            r_last_b <= 1'b1;
        end else begin
            r_we     <= 1'b0;
        end
    end

    assign rf_we    = r_we;
    assign rf_wa    = r_wa;
    assign rf_wd    = r_wd;
    assign fwd_data = r_wd;

    assign fwd1 = r_we && (rd_a1 != '0) && (rd_a1 == r_wa);
    assign fwd2 = r_we && (rd_a2 != '0) && (rd_a2 == r_wa);

    // Any in-flight request to the read address is a hazard, granted or not.
    assign haz1 = (rd_a1 != '0) &&
                  ((a_valid && (a_addr == rd_a1)) || (b_valid && (b_addr == rd_a1)));
    assign haz2 = (rd_a2 != '0) &&
                  ((a_valid && (a_addr == rd_a2)) || (b_valid && (b_addr == rd_a2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int N = 5;
    localparam int M = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_valid, b_valid;
    logic [N-1:0] a_addr, b_addr;
    logic [M-1:0] a_data, b_data;
    logic         a_ready, b_ready;
    logic         rf_we;
    logic [N-1:0] rf_wa;
    logic [M-1:0] rf_wd;
    logic [N-1:0] rd_a1, rd_a2;
    logic         fwd1, fwd2, haz1, haz2;
    logic [M-1:0] fwd_data;

    int checks = 0;
    int failures = 0;

    // Reference model: who won last, and the most recent accepted write.
    int           last_winner;   // 0 = A, 1 = B
    bit           m_we;
    logic [N-1:0] m_wa;
    logic [M-1:0] m_wd;
    bit           a_taken, b_taken;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N(N), .M(M)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rd_a1(rd_a1), .rd_a2(rd_a2),
        .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data),
        .haz1(haz1), .haz2(haz2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hazard(input logic [N-1:0] ra);
        return (ra != 0) && ((a_valid && a_addr == ra) || (b_valid && b_addr == ra));
    endfunction

    // Called just after a negedge with inputs applied; checks this cycle, advances model past posedge.
    task automatic step();
        bit ga, gb;
        #1;
        ga = 0; gb = 0;
        if (!reset) begin
            if (a_valid && b_valid) begin
                ga = (last_winner == 1);
                gb = (last_winner == 0);
            end else begin
                ga = a_valid;
                gb = b_valid;
            end
        end
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        check("rf_we", rf_we, m_we);
        check("rf_wa", rf_wa, m_wa);
        check("rf_wd", rf_wd, m_wd);
        check("fwd_data", fwd_data, m_wd);
        check("fwd1", fwd1, m_we && rd_a1 != 0 && rd_a1 == m_wa);
        check("fwd2", fwd2, m_we && rd_a2 != 0 && rd_a2 == m_wa);
        check("haz1", haz1, hazard(rd_a1));
        check("haz2", haz2, hazard(rd_a2));
        a_taken = ga;
        b_taken = gb;
        if (reset) begin
            m_we = 0; m_wa = 0; m_wd = 0; last_winner = 1;
        end else if (ga) begin
            m_we = (a_addr != 0); m_wa = a_addr; m_wd = a_data; last_winner = 0;
        end else if (gb) begin
            m_we = (b_addr != 0); m_wa = b_addr; m_wd = b_data; last_winner = 1;
        end else begin
            m_we = 0;
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit av, input int aa, input int ad,
                          input bit bv, input int ba, input int bd,
                          input int r1, input int r2, input bit rst);
        a_valid = av; a_addr = N'(aa); a_data = M'(ad);
        b_valid = bv; b_addr = N'(ba); b_data = M'(bd);
        rd_a1 = N'(r1); rd_a2 = N'(r2); reset = rst;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        m_we = 0; m_wa = 0; m_wd = 0; last_winner = 1;
        repeat (2) @(negedge clk);
        step();                                   // reset state

        // A only
        set_in(1, 3, 100, 0, 0, 0, 3, 0, 0);
        #1 check("a_only_ready", a_ready, 1'b1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 3, 0, 0);
        #1 check("a_only_we", rf_we, 1'b1);
        check("a_only_wa", rf_wa, 3);
        check("a_only_wd", rf_wd, 100);
        check("a_only_fwd1", fwd1, 1'b1);
        step();

        // Contention after reset: A first, then B
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        set_in(1, 5, 'h11, 1, 6, 'h22, 0, 0, 0);
        #1 check("cont_a_first", a_ready, 1'b1);
        step();
        set_in(0, 0, 0, 1, 6, 'h22, 0, 0, 0);
        #1 check("cont_wa5", rf_wa, 5);
        check("cont_b_second", b_ready, 1'b1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("cont_wa6", rf_wa, 6);
        check("cont_wd22", rf_wd, 'h22);
        step();

        // Register 0 write dropped
        set_in(0, 0, 0, 1, 0, 7, 0, 0, 0);
        #1 check("r0_ready", b_ready, 1'b1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("r0_we", rf_we, 1'b0);
        check("r0_haz1", haz1, 1'b0);
        step();

        // Hazard then forward; B won last so A wins contention here
        set_in(1, 9, 'h99, 1, 4, 'h44, 0, 9, 0);
        #1 check("haz_pending", haz2, 1'b1);
        step();
        set_in(0, 0, 0, 1, 4, 'h44, 0, 9, 0);
        #1 check("haz_fwd2", fwd2, 1'b1);
        check("haz_fwd_data", fwd_data, 'h99);
        step();

        // Reset right after a transfer
        set_in(1, 12, 'h5a, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        set_in(1, 13, 1, 1, 14, 2, 0, 0, 0);
        #1 check("rst_drop_we", rf_we, 1'b0);
        check("rst_a_first", a_ready, 1'b1);
        step();

        // Randomized traffic with requesters holding until granted
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        a_taken = 1; b_taken = 1;
        for (int i = 0; i < 3000; i++) begin
            if (a_taken || !a_valid) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_addr  = N'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (b_taken || !b_valid) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = N'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            rd_a1 = N'($urandom_range(0, 7));
            rd_a2 = N'($urandom_range(0, 7));
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N, default 5, register address width.
REQ-002 SHALL have parameter M, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a_valid/b_valid  input  1 each  write request from requester A (ALU writeback) and requester B (load/multi-cycle unit).
REQ-006 SHALL have ports a_addr/b_addr  input  N each  destination register of each request.
REQ-007 SHALL have ports a_data/b_data  input  M each  write data of each request.
REQ-008 SHALL have ports a_ready/b_ready  output  1 each  grant; a request transfers when valid and ready are both high at posedge clk.
REQ-009 SHALL have ports rf_we, rf_wa, rf_wd  output  1/N/M  registered write port driving the register file we3/a3/wd3.
REQ-010 SHALL have ports rd_a1, rd_a2  input  N each  read addresses currently presented to the register file.
REQ-011 SHALL have ports fwd1, fwd2  output  1 each  forward hit for rd_a1/rd_a2.
REQ-012 SHALL have port fwd_data  output  M  forwarded value (equals rf_wd).
REQ-013 SHALL have ports haz1, haz2  output  1 each  read hazard for rd_a1/rd_a2 (stall reader).

Function
REQ-014 SHALL grant at most one requester per cycle; a_ready and b_ready never both high.
REQ-015 SHALL grant A when only a_valid is high and B when only b_valid is high, in the same cycle (combinational ready).
REQ-016 SHALL, when both valid, grant the requester not granted most recently (round-robin via a 1-bit last_grant register).
REQ-017 SHALL update last_grant only on a completed transfer; idle cycles leave it unchanged.
REQ-018 SHALL drive both ready low when neither valid is high.
REQ-019 SHALL register the granted request: cycle t handshake -> cycle t+1 rf_we=1, rf_wa=addr, rf_wd=data; register file commits at end of t+1 (latency 1).
REQ-020 SHALL complete handshakes with addr 0 normally but hold rf_we=0 in the following cycle (writes to register 0 dropped).
REQ-021 SHALL hold rf_we=0 in any cycle following a cycle with no transfer; rf_wa/rf_wd then hold their previous values.
REQ-022 SHALL sustain one write per cycle under continuous requests (no bubbles).
REQ-023 SHALL keep a non-granted request pending with no state stored for it; the requester holds valid/addr/data stable until granted.
REQ-024 SHALL assert fwd1 when rf_we=1, rd_a1!=0 and rd_a1==rf_wa; fwd2 likewise for rd_a2; fwd_data = rf_wd.
REQ-025 SHALL assert haz1 when rd_a1!=0 and (a_valid with a_addr==rd_a1 or b_valid with b_addr==rd_a1), granted this cycle or not; haz2 likewise.
REQ-026 SHALL, when A and B both target the same address in consecutive transfers, commit them in grant order so the later grant's data persists.
REQ-027 SHALL compute fwd and haz combinationally; they are never asserted for address 0.

Reset
REQ-028 SHALL, while reset is high at posedge clk, clear rf_we, rf_wa and rf_wd to 0 and set last_grant=B, so A wins the first contention.
REQ-029 SHALL hold a_ready=b_ready=0 while reset is high; requests presented during reset are not accepted.
REQ-030 SHALL drop a write already registered in the stage when reset asserts (rf_we=0 the cycle after reset).

Verification
REQ-031 A only: a_valid=1, a_addr=3, a_data=100 -> a_ready=1 same cycle; next cycle rf_we=1, rf_wa=3, rf_wd=100; fwd1=1 when rd_a1=3.
REQ-032 Contention after reset: A(5,0x11) and B(6,0x22) held valid 2 cycles -> grants A then B; rf writes 5<-0x11 then 6<-0x22 on consecutive cycles.
REQ-033 Register 0: b_valid=1, b_addr=0, b_data=7 -> b_ready=1; next cycle rf_we=0; haz1=fwd1=0 with rd_a1=0.
REQ-034 Hazard: a_valid=1, a_addr=9 with b pending, rd_a2=9 -> haz2=1 until A's write reaches the stage, then fwd2=1 with fwd_data=A's data.
REQ-035 Reset mid-operation: transfer at t, reset high at t+1 -> rf_we=0 after reset; next contention grants A first.
